// File: rtl/siso_frame_rx.sv
// Deframer/deserializer for the SISO serial output: start(1), DATA_W bits LSB-first, [parity], stop(0).
// Optional even-parity bit compiled in with `define SISO_RX_PARITY_EN.
module siso_frame_rx #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  input  logic              si_vld,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              frame_err,
  output logic              par_err,
  output logic              overrun,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

`ifdef SISO_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bad;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      overrun   <= 1'b0;
      // A load later in this block overrides the drain, keeping dout_vld high.
      if (dout_vld && dout_rdy)
        dout_vld <= 1'b0;
      if (si_vld) begin
        unique case (state)
          IDLE: begin
            if (si) begin
              state   <= DATA;
              bit_cnt <= '0;
              par_bad <= 1'b0;
            end
          end
          DATA: begin
            // Right-shift in: after DATA_W bits the first (LSB) bit sits in bit 0.
            shreg   <= {si, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef SISO_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef SISO_RX_PARITY_EN
          PARITY: begin
            par_bad <= (^shreg) ^ si;
            state   <= STOP;
          end
`endif
          STOP: begin
            state <= IDLE;
            if (si)
              frame_err <= 1'b1;
            else if (par_bad)
              par_err <= 1'b1;
            else if (!dout_vld || dout_rdy) begin
              dout     <= shreg;
              dout_vld <= 1'b1;
              if (frame_cnt != '1)
                frame_cnt <= frame_cnt + 1'b1;
            end else
              overrun <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_siso_frame_rx.sv
// Self-checking bench for siso_frame_rx: directed literal checks plus randomized frames
// compared every cycle against a frame-level reference model.
module tb_siso_frame_rx;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
`ifdef SISO_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = DATA_W + 2;
`else
  localparam int unsigned FRAME_BITS = DATA_W + 1;
`endif

  logic              clk = 1'b0;
  logic              rst, si, si_vld, dout_rdy;
  logic [DATA_W-1:0] dout;
  logic              dout_vld, frame_err, par_err, overrun, busy;
  logic [CNT_W-1:0]  frame_cnt;

  siso_frame_rx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .si(si), .si_vld(si_vld),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .frame_err(frame_err), .par_err(par_err), .overrun(overrun),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 0;
  bit rnd_rdy = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collect the bits after a start bit, judge the whole frame once complete.
  bit                bits[$];
  bit                m_active = 0;
  logic [DATA_W-1:0] exp_dout = '0;
  logic              exp_vld = 0, exp_ferr = 0, exp_perr = 0, exp_ovr = 0;
  logic [CNT_W-1:0]  exp_cnt = '0;

  always @(posedge clk) begin
    logic              old_vld, pok, stop_b;
    logic [DATA_W-1:0] w;
    exp_ferr = 0; exp_perr = 0; exp_ovr = 0;
    if (!rst) begin
      m_active = 0; bits.delete();
      exp_dout = '0; exp_vld = 0; exp_cnt = '0;
    end else begin
      old_vld = exp_vld;
      if (exp_vld && dout_rdy) exp_vld = 0;
      if (si_vld) begin
        if (!m_active) begin
          if (si) begin m_active = 1; bits.delete(); end
        end else begin
          bits.push_back(si);
          if (bits.size() == FRAME_BITS) begin
            m_active = 0;
            w = '0;
            for (int i = 0; i < DATA_W; i++) w[i] = bits[i];
            stop_b = bits[FRAME_BITS-1];
`ifdef SISO_RX_PARITY_EN
            pok = ((^w) ^ bits[DATA_W]) == 1'b0;
`else
            pok = 1'b1;
`endif
            if (stop_b) exp_ferr = 1;
            else if (!pok) exp_perr = 1;
            else if (!old_vld || dout_rdy) begin
              exp_dout = w; exp_vld = 1;
              if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1;
            end else exp_ovr = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("dout", 32'(dout), 32'(exp_dout));
      chk("dout_vld", 32'(dout_vld), 32'(exp_vld));
      chk("frame_err", 32'(frame_err), 32'(exp_ferr));
      chk("par_err", 32'(par_err), 32'(exp_perr));
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      chk("busy", 32'(busy), 32'(m_active));
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    end
  end

  // Called at a negedge: apply inputs, return at the next negedge.
  task automatic drive(input logic b, input logic v);
    si = b; si_vld = v;
    if (rnd_rdy) dout_rdy = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  // mode 0: back-to-back bits, 1: an invalid cycle after each bit, 2: random invalid gaps
  task automatic vbit(input logic b, input int unsigned mode);
    drive(b, 1'b1);
    if (mode == 1) drive(~b, 1'b0);
    else if (mode == 2)
      for (int unsigned i = $urandom_range(0, 2); i > 0; i--) drive(1'($urandom_range(0, 1)), 1'b0);
  endtask

  // rdy_stop: 0/1 forces dout_rdy on the stop-bit cycle, 2 leaves it alone.
  task automatic send_frame(input logic [DATA_W-1:0] w, input logic bad_par, input logic stop_b,
                            input int unsigned mode, input int unsigned rdy_stop);
    vbit(1'b1, mode);
    for (int unsigned i = 0; i < DATA_W; i++) vbit(w[i], mode);
`ifdef SISO_RX_PARITY_EN
    vbit((^w) ^ bad_par, mode);
`else
    if (bad_par) begin end
`endif
    si = stop_b; si_vld = 1'b1;
    if (rnd_rdy) dout_rdy = 1'($urandom_range(0, 1));
    else if (rdy_stop != 2) dout_rdy = rdy_stop[0];
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; si = 1'b0; si_vld = 1'b0; dout_rdy = 1'b0;
    @(negedge clk);
    checking = 1;
    idle(1);
    chk("rst_vld", 32'(dout_vld), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt", 32'(frame_cnt), 32'h0);
    rst = 1'b1;
    dout_rdy = 1'b1;
    idle(2);

    send_frame(8'h3C, 1'b0, 1'b0, 0, 2);
    chk("f3c_vld", 32'(dout_vld), 32'h1);
    chk("f3c_dout", 32'(dout), 32'h3C);
    chk("f3c_cnt", 32'(frame_cnt), 32'h1);
    idle(2);

    drive(1'b1, 1'b1); drive(1'b1, 1'b1); drive(1'b0, 1'b1); drive(1'b1, 1'b1);
    rst = 1'b0;
    idle(2);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_vld", 32'(dout_vld), 32'h0);
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'h0);
    rst = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0, 0, 2);
    chk("fa5_dout", 32'(dout), 32'hA5);
    chk("fa5_cnt", 32'(frame_cnt), 32'h1);
    idle(1);
    send_frame(8'h3C, 1'b0, 1'b0, 0, 2);
    chk("f3c2_cnt", 32'(frame_cnt), 32'h2);
    idle(1);

    send_frame(8'h12, 1'b0, 1'b0, 1, 2);
    chk("f12_dout", 32'(dout), 32'h12);
    chk("f12_cnt", 32'(frame_cnt), 32'h3);
    idle(1);

    send_frame(8'h5A, 1'b0, 1'b1, 0, 2);
    chk("ferr_pulse", 32'(frame_err), 32'h1);
    chk("ferr_vld", 32'(dout_vld), 32'h0);
    chk("ferr_cnt", 32'(frame_cnt), 32'h3);
    send_frame(8'h55, 1'b0, 1'b0, 0, 2);
    chk("f55_dout", 32'(dout), 32'h55);
    chk("f55_cnt", 32'(frame_cnt), 32'h4);
    idle(2);

    dout_rdy = 1'b0;
    send_frame(8'h01, 1'b0, 1'b0, 0, 2);
    chk("f01_dout", 32'(dout), 32'h01);
    chk("f01_cnt", 32'(frame_cnt), 32'h5);
    idle(1);
    send_frame(8'h02, 1'b0, 1'b0, 0, 2);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_dout", 32'(dout), 32'h01);
    chk("ovr_cnt", 32'(frame_cnt), 32'h5);
    dout_rdy = 1'b0;
    idle(1);
    send_frame(8'h02, 1'b0, 1'b0, 0, 1);
    chk("acc_load_ovr", 32'(overrun), 32'h0);
    chk("acc_load_dout", 32'(dout), 32'h02);
    chk("acc_load_vld", 32'(dout_vld), 32'h1);
    chk("acc_load_cnt", 32'(frame_cnt), 32'h6);
    idle(2);

`ifdef SISO_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b0, 0, 2);
    chk("par_ok_dout", 32'(dout), 32'h07);
    chk("par_ok_cnt", 32'(frame_cnt), 32'h7);
    idle(2);
    send_frame(8'h07, 1'b1, 1'b0, 0, 2);
    chk("par_bad_pulse", 32'(par_err), 32'h1);
    chk("par_bad_vld", 32'(dout_vld), 32'h0);
    chk("par_bad_cnt", 32'(frame_cnt), 32'h7);
    idle(2);
`endif

    rnd_rdy = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0; idle($urandom_range(1, 2)); rst = 1'b1;
      end
      send_frame(DATA_W'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2), 2);
      for (int unsigned g = $urandom_range(0, 3); g > 0; g--) drive(1'b0, 1'($urandom_range(0, 1)));
    end
    rnd_rdy = 0;
    dout_rdy = 1'b1;
    idle(2);

    for (int k = 0; k < 16; k++) send_frame(DATA_W'($urandom), 1'b0, 1'b0, 0, 2);
    chk("sat_cnt", 32'(frame_cnt), 32'hF);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
